udp_recv: RTL and testbench

- Receive-side counterpart of the team's UDP transmitter.
- Parses an 8-bit GMII/MII-style byte stream: preamble/SFD, Ethernet II, IPv4 (IHL=5, no options), UDP.
- Filters frames by own MAC, IP and port; streams the UDP payload cut-through to the consumer.
- Gives a good/bad verdict after the Ethernet FCS check. The consumer discards the buffered payload when the verdict is bad.

---
 rtl/udp_recv.sv | 237 +++++++++++++++++++++++
 tb/tb_udp_recv.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_recv.sv
// UDP receiver: parses preamble, Ethernet II, IPv4 and UDP headers,
// filters on own MAC/IP/port, streams payload and reports the FCS verdict.
module udp_recv #(
  parameter bit CHECK_IP_CSUM = 1'b1,
  parameter bit ACCEPT_BCAST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_dv,
  input  logic        i_rx_er,
  input  logic [47:0] i_my_mac,
  input  logic [31:0] i_my_ip,
  input  logic [15:0] i_my_port,
  output logic [7:0]  o_data,
  output logic        o_data_vl,
  output logic        o_sof,
  output logic        o_eof,
  output logic [15:0] o_data_len,
  output logic [47:0] o_src_mac,
  output logic [31:0] o_src_ip,
  output logic [15:0] o_src_port,
  output logic        o_pkt_done,
  output logic        o_pkt_good
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, DST_MAC, SRC_MAC, ETH_TYPE,
    IP_HDR, UDP_HDR, PAYLOAD, TAIL, DROP
  } state_t;

  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RES  = 32'hDEBB20E3;

  state_t      state;
  logic [15:0] cnt;
  logic [7:0]  hi;
  logic [39:0] dst_sh;
  logic [47:0] smac;
  logic [31:0] sip;
  logic [15:0] sport;
  logic [15:0] ulen;
  logic [31:0] acc;
  logic        bad;
  logic        err;
  logic [31:0] crc;

  function automatic logic [31:0] crc8(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  logic [15:0] word;
  logic [47:0] mac_full;
  logic        mac_ok;
  logic [31:0] csum_sum;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        csum_ok;
  logic [7:0]  ip_byte;
  logic        in_crc;
  logic        pre_udp;

  assign word     = {hi, i_rx_data};
  assign mac_full = {dst_sh, i_rx_data};
  assign mac_ok   = (mac_full == i_my_mac) ||
                    (ACCEPT_BCAST && (&mac_full));
  assign csum_sum = acc + {16'h0, word};
  assign fold1    = {1'b0, csum_sum[15:0]} +
                    {1'b0, csum_sum[31:16]};
  assign fold2    = fold1[15:0] + {15'h0, fold1[16]};
  assign csum_ok  = !CHECK_IP_CSUM || (fold2 == 16'hFFFF);

  always_comb begin
    ip_byte = i_my_ip[7:0];
    case (cnt[1:0])
      2'd0:    ip_byte = i_my_ip[31:24];
      2'd1:    ip_byte = i_my_ip[23:16];
      2'd2:    ip_byte = i_my_ip[15:8];
      default: ip_byte = i_my_ip[7:0];
    endcase
  end

  assign in_crc  = state inside {DST_MAC, SRC_MAC, ETH_TYPE,
                                 IP_HDR, UDP_HDR, PAYLOAD, TAIL};
  assign pre_udp = state inside {PREAMBLE, DST_MAC, SRC_MAC,
                                 ETH_TYPE, IP_HDR, UDP_HDR};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= '0;
      dst_sh     <= '0;
      smac       <= '0;
      sip        <= '0;
      sport      <= '0;
      ulen       <= '0;
      acc        <= '0;
      bad        <= 1'b0;
      err        <= 1'b0;
      crc        <= CRC_INIT;
      o_data     <= '0;
      o_data_vl  <= 1'b0;
      o_sof      <= 1'b0;
      o_eof      <= 1'b0;
      o_data_len <= '0;
      o_src_mac  <= '0;
      o_src_ip   <= '0;
      o_src_port <= '0;
      o_pkt_done <= 1'b0;
      o_pkt_good <= 1'b0;
    end else begin
      o_data_vl  <= 1'b0;
      o_sof      <= 1'b0;
      o_eof      <= 1'b0;
      o_pkt_done <= 1'b0;
      o_pkt_good <= 1'b0;
      if (i_rx_dv) begin
        hi  <= i_rx_data;
        cnt <= cnt + 16'd1;
        if (in_crc) crc <= crc8(crc, i_rx_data);
        if (i_rx_er && pre_udp) begin
          state <= DROP;
          cnt   <= '0;
        end else begin
          if (i_rx_er) err <= 1'b1;
          case (state)
            IDLE: begin
              state <= PREAMBLE;
              cnt   <= '0;
              err   <= 1'b0;
            end
            PREAMBLE: begin
              crc <= CRC_INIT;
              if (i_rx_data == 8'hD5) begin
                state <= DST_MAC;
                cnt   <= '0;
              end else if (i_rx_data != 8'h55) begin
                state <= DROP;
                cnt   <= '0;
              end
            end
            DST_MAC: begin
              dst_sh <= mac_full[39:0];
              if (cnt == 16'd5) begin
                state <= mac_ok ? SRC_MAC : DROP;
                cnt   <= '0;
              end
            end
            SRC_MAC: begin
              smac <= {smac[39:0], i_rx_data};
              if (cnt == 16'd5) begin
                state <= ETH_TYPE;
                cnt   <= '0;
              end
            end
            ETH_TYPE: begin
              if (cnt == 16'd1) begin
                state <= (word == 16'h0800) ? IP_HDR : DROP;
                cnt   <= '0;
                bad   <= 1'b0;
                acc   <= '0;
              end
            end
            IP_HDR: begin
              if (cnt[0]) acc <= csum_sum;
              if (cnt == 16'd0 && i_rx_data != 8'h45) bad <= 1'b1;
              if (cnt == 16'd6 && i_rx_data[5:0] != 6'd0) bad <= 1'b1;
              if (cnt == 16'd7 && i_rx_data != 8'h00) bad <= 1'b1;
              if (cnt == 16'd9 && i_rx_data != 8'd17) bad <= 1'b1;
              if (cnt >= 16'd12 && cnt <= 16'd15)
                sip <= {sip[23:0], i_rx_data};
              if (cnt >= 16'd16 && i_rx_data != ip_byte) bad <= 1'b1;
              // the last address byte and checksum are judged in the same cycle
              if (cnt == 16'd19) begin
                state <= (bad || i_rx_data != ip_byte || !csum_ok)
                         ? DROP : UDP_HDR;
                cnt   <= '0;
                bad   <= 1'b0;
              end
            end
            UDP_HDR: begin
              if (cnt == 16'd1) sport <= word;
              if (cnt == 16'd3 && word != i_my_port) bad <= 1'b1;
              if (cnt == 16'd5) begin
                ulen <= word;
                if (word < 16'd8) bad <= 1'b1;
              end
              if (cnt == 16'd7) begin
                cnt <= '0;
                if (bad) begin
                  state <= DROP;
                end else begin
                  o_data_len <= ulen - 16'd8;
                  o_src_mac  <= smac;
                  o_src_ip   <= sip;
                  o_src_port <= sport;
                  state      <= (ulen > 16'd8) ? PAYLOAD : TAIL;
                end
              end
            end
            PAYLOAD: begin
              o_data    <= i_rx_data;
              o_data_vl <= 1'b1;
              o_sof     <= (cnt == 16'd0);
              if (cnt == o_data_len - 16'd1) begin
                o_eof <= 1'b1;
                state <= TAIL;
                cnt   <= '0;
              end
            end
            default: ;
          endcase
        end
      end else begin
        case (state)
          TAIL: begin
            o_pkt_done <= 1'b1;
            o_pkt_good <= (crc == CRC_RES) && !err;
          end
          PAYLOAD: o_pkt_done <= 1'b1;
          default: ;
        endcase
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_udp_recv.sv
// Bench for udp_recv: frames are built from field values, expected
// results come from the header filter rules and a byte-level CRC model.
module tb_udp_recv;

  localparam logic [47:0] MY_MAC  = 48'h02_11_22_33_44_55;
  localparam logic [31:0] MY_IP   = 32'h0A00_0001;
  localparam logic [15:0] MY_PORT = 16'd6000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_dv = 1'b0;
  logic rx_er = 1'b0;

  logic [7:0]  o_data, z_data;
  logic        o_data_vl, z_data_vl;
  logic        o_sof, z_sof, o_eof, z_eof;
  logic [15:0] o_data_len, z_data_len;
  logic [47:0] o_src_mac, z_src_mac;
  logic [31:0] o_src_ip, z_src_ip;
  logic [15:0] o_src_port, z_src_port;
  logic        o_pkt_done, z_pkt_done;
  logic        o_pkt_good, z_pkt_good;

  udp_recv dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_dv(rx_dv), .i_rx_er(rx_er),
    .i_my_mac(MY_MAC), .i_my_ip(MY_IP), .i_my_port(MY_PORT),
    .o_data(o_data), .o_data_vl(o_data_vl),
    .o_sof(o_sof), .o_eof(o_eof), .o_data_len(o_data_len),
    .o_src_mac(o_src_mac), .o_src_ip(o_src_ip),
    .o_src_port(o_src_port),
    .o_pkt_done(o_pkt_done), .o_pkt_good(o_pkt_good)
  );

  udp_recv #(.CHECK_IP_CSUM(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_dv(rx_dv), .i_rx_er(rx_er),
    .i_my_mac(MY_MAC), .i_my_ip(MY_IP), .i_my_port(MY_PORT),
    .o_data(z_data), .o_data_vl(z_data_vl),
    .o_sof(z_sof), .o_eof(z_eof), .o_data_len(z_data_len),
    .o_src_mac(z_src_mac), .o_src_ip(z_src_ip),
    .o_src_port(z_src_port),
    .o_pkt_done(z_pkt_done), .o_pkt_good(z_pkt_good)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got[$];
  int n_sof, n_eof, n_done, n_good, z_done, z_good;
  int sof_cyc, eof_pos, in_cyc;

  always @(negedge clk) begin
    if (o_data_vl) got.push_back(o_data);
    if (o_sof) begin n_sof++; sof_cyc = cyc; end
    if (o_eof) begin n_eof++; eof_pos = got.size(); end
    if (o_pkt_done) begin n_done++; if (o_pkt_good) n_good++; end
    if (z_pkt_done) begin z_done++; if (z_pkt_good) z_good++; end
  end

  logic [47:0] f_dst, f_src;
  logic [15:0] f_etype, f_sport, f_dport;
  logic [31:0] f_sip, f_dip;
  logic [7:0]  f_pay[$];
  int          f_pad;
  bit          f_bad_csum, f_bad_fcs;
  logic [7:0]  fr[$];

  function automatic logic [31:0] crc_upd(
    input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // frame acceptance from the header filter rules
  function automatic bit accepts(input bit chk);
    return (f_dst == MY_MAC || f_dst == '1) &&
           f_etype == 16'h0800 && f_dip == MY_IP &&
           f_dport == MY_PORT && !(chk && f_bad_csum);
  endfunction

  function automatic int pay_mism(input int n);
    int m = 0;
    if (got.size() != n) m++;
    for (int i = 0; i < n && i < got.size(); i++)
      if (got[i] !== f_pay[i]) m++;
    return m;
  endfunction

  task automatic set_good();
    f_dst = MY_MAC;
    f_src = 48'h0A_BB_CC_DD_EE_01;
    f_etype = 16'h0800;
    f_sip = 32'h0A00_0002;
    f_dip = 32'h0A00_0009 - 32'd8;
    f_sport = 16'd5000;
    f_dport = MY_PORT;
    f_pay.delete();
    for (int i = 0; i < 16; i++) f_pay.push_back(8'(i));
    f_pad = 2;
    f_bad_csum = 0;
    f_bad_fcs = 0;
  endtask

  task automatic build();
    logic [7:0] h[20];
    logic [31:0] s, c;
    logic [15:0] ul, tl, cs;
    fr.delete();
    ul = 16'(8 + f_pay.size());
    tl = ul + 16'd20;
    for (int i = 5; i >= 0; i--) fr.push_back(f_dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) fr.push_back(f_src[8*i +: 8]);
    fr.push_back(f_etype[15:8]);
    fr.push_back(f_etype[7:0]);
    h = '{8'h45, 8'h00, tl[15:8], tl[7:0], 8'h12, 8'h34,
          8'h40, 8'h00, 8'h40, 8'd17, 8'h00, 8'h00,
          f_sip[31:24], f_sip[23:16], f_sip[15:8], f_sip[7:0],
          f_dip[31:24], f_dip[23:16], f_dip[15:8], f_dip[7:0]};
    s = 0;
    for (int i = 0; i < 10; i++) s += {16'h0, h[2*i], h[2*i+1]};
    while (s[31:16] != 0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    cs = ~s[15:0];
    if (f_bad_csum) cs ^= 16'h0100;
    h[10] = cs[15:8];
    h[11] = cs[7:0];
    for (int i = 0; i < 20; i++) fr.push_back(h[i]);
    fr.push_back(f_sport[15:8]); fr.push_back(f_sport[7:0]);
    fr.push_back(f_dport[15:8]); fr.push_back(f_dport[7:0]);
    fr.push_back(ul[15:8]);      fr.push_back(ul[7:0]);
    fr.push_back(8'h00);         fr.push_back(8'h00);
    foreach (f_pay[i]) fr.push_back(f_pay[i]);
    for (int i = 0; i < f_pad; i++) fr.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (fr[i]) c = crc_upd(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    if (f_bad_fcs) fr[fr.size()-1] ^= 8'h01;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic e);
    @(posedge clk); #1;
    rx_dv = 1'b1; rx_data = b; rx_er = e;
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_er = 1'b0;
  endtask

  task automatic send_pre();
    repeat (7) drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
  endtask

  // cut: number of frame bytes after the SFD to send (-1 = all)
  task automatic send(input int cut, input int er_at);
    int n;
    n = (cut < 0) ? fr.size() : cut;
    send_pre();
    for (int i = 0; i < n; i++) begin
      drive_byte(fr[i], i == er_at);
      if (i == 42) in_cyc = cyc;
    end
    end_frame();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got.delete();
    n_sof = 0; n_eof = 0; n_done = 0; n_good = 0;
    z_done = 0; z_good = 0; eof_pos = -1; sof_cyc = -1;
  endtask

  task automatic test_reset();
    idle(3);
    checks++;
    if ({o_data, o_data_vl, o_sof, o_eof, o_data_len, o_src_mac,
         o_src_ip, o_src_port, o_pkt_done, o_pkt_good} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got len=%0d port=%0d vl=%b done=%b want all 0",
               o_data_len, o_src_port, o_data_vl, o_pkt_done);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good();
    set_good(); build(); clear();
    send(-1, -1); idle(4);
    checks++;
    if (pay_mism(16) != 0) begin errors++;
      $display("FAIL good_payload got %0d bytes, %0d mismatches want 16/0",
               got.size(), pay_mism(16)); end
    checks++;
    if (n_sof != 1 || n_eof != 1 || eof_pos != 16) begin errors++;
      $display("FAIL good_sof_eof got sof=%0d eof=%0d pos=%0d want 1 1 16",
               n_sof, n_eof, eof_pos); end
    checks++;
    if (sof_cyc != in_cyc + 1) begin errors++;
      $display("FAIL good_latency got %0d want %0d", sof_cyc, in_cyc + 1); end
    checks++;
    if (o_data_len !== 16'd16 || o_src_port !== 16'd5000) begin errors++;
      $display("FAIL good_len_port got %0d %0d want 16 5000",
               o_data_len, o_src_port); end
    checks++;
    if (o_src_mac !== f_src || o_src_ip !== f_sip) begin errors++;
      $display("FAIL good_src got %h %h want %h %h",
               o_src_mac, o_src_ip, f_src, f_sip); end
    checks++;
    if (n_done != 1 || n_good != 1) begin errors++;
      $display("FAIL good_verdict got done=%0d good=%0d want 1 1",
               n_done, n_good); end
  endtask

  task automatic test_fcs_err();
    set_good(); f_bad_fcs = 1; build(); clear();
    send(-1, -1); idle(4);
    checks++;
    if (pay_mism(16) != 0 || n_eof != 1) begin errors++;
      $display("FAIL fcs_payload got %0d bytes eof=%0d want 16 1",
               got.size(), n_eof); end
    checks++;
    if (n_done != 1 || n_good != 0) begin errors++;
      $display("FAIL fcs_verdict got done=%0d good=%0d want 1 0",
               n_done, n_good); end
  endtask

  task automatic test_filter();
    for (int k = 0; k < 4; k++) begin
      set_good();
      case (k)
        0: f_dst ^= 48'h0000_0000_0100;
        1: f_dip = 32'h0A00_0009;
        2: f_dport = 16'd6001;
        default: f_etype = 16'h0806;
      endcase
      build(); clear(); send(-1, -1); idle(4);
      checks++;
      if (got.size() != 0 || n_done != 0) begin errors++;
        $display("FAIL filter_%0d got bytes=%0d done=%0d want 0 0",
                 k, got.size(), n_done); end
      set_good(); build(); clear(); send(-1, -1); idle(4);
      checks++;
      if (pay_mism(16) != 0 || n_good != 1) begin errors++;
        $display("FAIL filter_next_%0d got bytes=%0d good=%0d want 16 1",
                 k, got.size(), n_good); end
    end
  endtask

  task automatic test_ip_csum();
    set_good(); f_bad_csum = 1; build(); clear();
    send(-1, -1); idle(4);
    checks++;
    if (got.size() != 0 || n_done != 0) begin errors++;
      $display("FAIL csum_drop got bytes=%0d done=%0d want 0 0",
               got.size(), n_done); end
    checks++;
    if (z_done != 1 || z_good != 1) begin errors++;
      $display("FAIL csum_nocheck got done=%0d good=%0d want 1 1",
               z_done, z_good); end
  endtask

  task automatic test_trunc();
    set_good(); build(); clear();
    send(42 + 5, -1); idle(4);
    checks++;
    if (pay_mism(5) != 0 || n_eof != 0) begin errors++;
      $display("FAIL trunc_payload got bytes=%0d eof=%0d want 5 0",
               got.size(), n_eof); end
    checks++;
    if (n_done != 1 || n_good != 0) begin errors++;
      $display("FAIL trunc_verdict got done=%0d good=%0d want 1 0",
               n_done, n_good); end
  endtask

  task automatic test_rx_er();
    set_good(); build(); clear();
    send(-1, 42 + 3); idle(4);
    checks++;
    if (pay_mism(16) != 0 || n_done != 1 || n_good != 0) begin errors++;
      $display("FAIL rx_er got bytes=%0d done=%0d good=%0d want 16 1 0",
               got.size(), n_done, n_good); end
  endtask

  task automatic test_bcast();
    set_good(); f_dst = '1; build(); clear();
    send(-1, -1); idle(4);
    checks++;
    if (pay_mism(16) != 0 || n_good != 1) begin errors++;
      $display("FAIL bcast got bytes=%0d good=%0d want 16 1",
               got.size(), n_good); end
  endtask

  task automatic test_reset_mid();
    set_good(); build(); clear();
    send_pre();
    for (int i = 0; i < 42 + 6; i++) drive_byte(fr[i], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0; rx_dv = 1'b0;
    #1;
    checks++;
    if ({o_data, o_data_vl, o_sof, o_eof, o_data_len, o_src_mac,
         o_src_ip, o_src_port, o_pkt_done, o_pkt_good} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got len=%0d port=%0d vl=%b want all 0",
               o_data_len, o_src_port, o_data_vl);
    end
    idle(2); rst_n = 1'b1; idle(4);
    checks++;
    if (n_done != 0) begin errors++;
      $display("FAIL rst_mid_done got %0d want 0", n_done); end
    clear(); send(-1, -1); idle(4);
    checks++;
    if (pay_mism(16) != 0 || n_good != 1) begin errors++;
      $display("FAIL rst_mid_next got bytes=%0d good=%0d want 16 1",
               got.size(), n_good); end
  endtask

  task automatic test_len8();
    set_good(); f_pay.delete(); f_pad = 10; build(); clear();
    send(-1, -1); idle(4);
    checks++;
    if (got.size() != 0 || n_sof != 0 || o_data_len !== 16'd0) begin errors++;
      $display("FAIL len8_data got bytes=%0d sof=%0d len=%0d want 0 0 0",
               got.size(), n_sof, o_data_len); end
    checks++;
    if (n_done != 1 || n_good != 1) begin errors++;
      $display("FAIL len8_verdict got done=%0d good=%0d want 1 1",
               n_done, n_good); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    int m;
    set_good(); f_pay.delete();
    for (int i = 0; i < 7; i++) f_pay.push_back(8'(8'hA0 + i));
    exp = f_pay;
    build(); clear(); send(-1, -1);
    f_pay.delete();
    for (int i = 0; i < 11; i++) f_pay.push_back(8'(8'h30 + i));
    foreach (f_pay[i]) exp.push_back(f_pay[i]);
    build(); send(-1, -1); idle(4);
    m = (got.size() != exp.size()) ? 1 : 0;
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (got[i] !== exp[i]) m++;
    checks++;
    if (m != 0) begin errors++;
      $display("FAIL b2b_payload got %0d bytes %0d mism want %0d",
               got.size(), m, exp.size()); end
    checks++;
    if (n_done != 2 || n_good != 2 || n_sof != 2) begin errors++;
      $display("FAIL b2b_verdict got done=%0d good=%0d sof=%0d want 2 2 2",
               n_done, n_good, n_sof); end
  endtask

  task automatic test_random();
    bit acc, acc0, good;
    int n, kind;
    for (int it = 0; it < 16; it++) begin
      set_good();
      f_src = {$urandom, $urandom} & 48'hFEFF_FFFF_FFFF;
      f_sip = $urandom;
      f_sport = 16'($urandom);
      f_pay.delete();
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++) f_pay.push_back(8'($urandom));
      f_pad = $urandom_range(0, 3);
      kind = $urandom_range(0, 7);
      case (kind)
        1: f_bad_fcs = 1;
        2: f_dst ^= 48'h1 << $urandom_range(0, 47);
        3: f_dip = MY_IP ^ (32'h1 << $urandom_range(0, 31));
        4: f_dport = MY_PORT + 16'd1;
        5: f_etype = 16'h86DD;
        6: f_bad_csum = 1;
        7: f_dst = '1;
        default: ;
      endcase
      acc = accepts(1'b1);
      acc0 = accepts(1'b0);
      good = acc && !f_bad_fcs;
      build(); clear(); send(-1, -1); idle(4);
      checks++;
      if (n_done != int'(acc) || n_good != int'(good)) begin errors++;
        $display("FAIL rand_%0d_verdict kind=%0d got %0d/%0d want %0d/%0d",
                 it, kind, n_done, n_good, acc, good); end
      checks++;
      if (pay_mism(acc ? n : 0) != 0) begin errors++;
        $display("FAIL rand_%0d_payload kind=%0d got %0d bytes want %0d",
                 it, kind, got.size(), acc ? n : 0); end
      checks++;
      if (z_done != int'(acc0)) begin errors++;
        $display("FAIL rand_%0d_nocheck kind=%0d got %0d want %0d",
                 it, kind, z_done, acc0); end
      if (acc) begin
        checks++;
        if (o_src_port !== f_sport || o_src_ip !== f_sip ||
            o_data_len !== 16'(n)) begin errors++;
          $display("FAIL rand_%0d_fields got %0d %h %0d want %0d %h %0d",
                   it, o_src_port, o_src_ip, o_data_len, f_sport, f_sip, n);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_fcs_err();
    test_filter();
    test_ip_csum();
    test_trunc();
    test_rx_er();
    test_bcast();
    test_reset_mid();
    test_len8();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
